// File: rtl/cp0_int_unit_if.sv
// CP0 register access bus used by mfc0/mtc0: register select, write strobe,
// write data and combinational read data.
interface cp0_int_unit_if;
    logic [4:0]  sel;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;

    modport master (output sel, output we, output din, input dout);
    modport slave  (input sel, input we, input din, output dout);
endinterface

// File: rtl/cp0_int_unit.sv
// Coprocessor-0 exception/interrupt unit: raises req to divert the pipeline,
// records the cause and return PC, and exposes SR/Cause/EPC/PRId to mfc0/mtc0.
module cp0_int_unit #(
    parameter logic [31:0] PRID_VAL   = 32'h4D49_5053,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
    input  logic                  clk,
    input  logic                  reset,
    cp0_int_unit_if.slave         bus,
    input  logic [31:0]           pc,
    input  logic                  bd,
    input  logic                  exc_valid,
    input  logic [4:0]            exc_code_in,
    input  logic                  eret,
    input  logic [5:0]            hw_int,
    output logic                  req,
    output logic [31:0]           handler_pc,
    output logic [31:0]           epc_out
);

    localparam logic [4:0] SEL_SR    = 5'd12;
    localparam logic [4:0] SEL_CAUSE = 5'd13;
    localparam logic [4:0] SEL_EPC   = 5'd14;
    localparam logic [4:0] SEL_PRID  = 5'd15;

    // The FSM state is the architectural EXL bit of SR.
    typedef enum logic {
        NORMAL  = 1'b0,
        HANDLER = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  im_q, im_d;
    logic        ie_q, ie_d;
    logic [5:0]  ip_q, ip_d;
    logic        bd_q, bd_d;
    logic [4:0]  exc_code_q, exc_code_d;
    logic [31:0] epc_q, epc_d;

    logic        exl;
    logic        int_req;
    logic        exc_req;
    logic [31:0] epc_target;

    assign handler_pc = HANDLER_PC;
    assign epc_out    = epc_q;
    assign exl        = (state_q == HANDLER);

    // Register update: state flops and all CP0 fields.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= NORMAL;
            im_q       <= '0;
            ie_q       <= 1'b0;
            ip_q       <= '0;
            bd_q       <= 1'b0;
            exc_code_q <= '0;
            epc_q      <= '0;
        end else begin
            state_q    <= state_d;
            im_q       <= im_d;
            ie_q       <= ie_d;
            ip_q       <= ip_d;
            bd_q       <= bd_d;
            exc_code_q <= exc_code_d;
            epc_q      <= epc_d;
        end
    end

    // Request decode and next-state: req beats mtc0, and mtc0 beats eret.
    always_comb begin
        state_d    = state_q;
        im_d       = im_q;
        ie_d       = ie_q;
        ip_d       = hw_int;
        bd_d       = bd_q;
        exc_code_d = exc_code_q;
        epc_d      = epc_q;

        int_req    = (|(hw_int & im_q)) & ie_q & ~exl;
        exc_req    = exc_valid & ~exl;
        req        = int_req | exc_req;
        epc_target = bd ? (pc - 32'd4) : pc;

        if (req) begin
            state_d    = HANDLER;
            exc_code_d = int_req ? 5'd0 : exc_code_in;
            bd_d       = bd;
            epc_d      = epc_target & 32'hFFFF_FFFC;
        end else begin
            if (eret) begin
                state_d = NORMAL;
            end
            // Applied after eret so a same-cycle SR write decides EXL.
            if (bus.we) begin
                case (bus.sel)
                    SEL_SR: begin
                        im_d    = bus.din[15:10];
                        ie_d    = bus.din[0];
                        state_d = bus.din[1] ? HANDLER : NORMAL;
                    end
                    SEL_EPC: begin
                        epc_d = {bus.din[31:2], 2'b00};
                    end
                    default: ;
                endcase
            end
        end
    end

    // mfc0 read mux on the pre-edge register values.
    always_comb begin
        case (bus.sel)
            SEL_SR:    bus.dout = {16'd0, im_q, 8'd0, exl, ie_q};
            SEL_CAUSE: bus.dout = {bd_q, 15'd0, ip_q, 3'd0, exc_code_q, 2'd0};
            SEL_EPC:   bus.dout = epc_q;
            SEL_PRID:  bus.dout = PRID_VAL;
            default:   bus.dout = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_int_unit.sv
// Scoreboard bench for cp0_int_unit: a word-level CP0 model predicts req,
// dout and epc_out for every driven cycle; a monitor checks mid-cycle.
module tb_cp0_int_unit;

    localparam logic [31:0] PRID = 32'h4D49_5053;
    localparam logic [31:0] HPC  = 32'h0000_4180;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        bd;
    logic        exc_valid;
    logic [4:0]  exc_code_in;
    logic        eret;
    logic [5:0]  hw_int;
    logic        req;
    logic [31:0] handler_pc;
    logic [31:0] epc_out;

    cp0_int_unit_if bus ();

    cp0_int_unit #(.PRID_VAL(PRID), .HANDLER_PC(HPC)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus.slave),
        .pc          (pc),
        .bd          (bd),
        .exc_valid   (exc_valid),
        .exc_code_in (exc_code_in),
        .eret        (eret),
        .hw_int      (hw_int),
        .req         (req),
        .handler_pc  (handler_pc),
        .epc_out     (epc_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        req;
        logic [31:0] dout;
        logic [31:0] epc;
        logic [4:0]  sel;
    } exp_t;

    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;

    // Architectural model: whole 32-bit register words.
    logic [31:0] m_sr, m_cause, m_epc;

    task automatic model_and_push();
        exp_t        e;
        logic        exl_m, ie_m, ireq, xreq;
        logic [5:0]  im_m;
        exl_m = m_sr[1];
        ie_m  = m_sr[0];
        im_m  = m_sr[15:10];
        ireq  = ((hw_int & im_m) != 6'd0) && ie_m && !exl_m;
        xreq  = exc_valid && !exl_m;
        e.req = ireq || xreq;
        e.sel = bus.sel;
        e.epc = m_epc;
        case (bus.sel)
            5'd12:   e.dout = m_sr;
            5'd13:   e.dout = m_cause;
            5'd14:   e.dout = m_epc;
            5'd15:   e.dout = PRID;
            default: e.dout = 32'd0;
        endcase
        sbq.push_back(e);

        if (reset) begin
            m_sr = 32'd0; m_cause = 32'd0; m_epc = 32'd0;
        end else begin
            m_cause[15:10] = hw_int;
            if (e.req) begin
                m_sr[1]       = 1'b1;
                m_cause[6:2]  = ireq ? 5'd0 : exc_code_in;
                m_cause[31]   = bd;
                m_epc         = bd ? pc - 32'd4 : pc;
            end else begin
                if (eret) m_sr[1] = 1'b0;
                if (bus.we && bus.sel == 5'd12) m_sr  = bus.din & 32'h0000_FC03;
                if (bus.we && bus.sel == 5'd14) m_epc = bus.din & 32'hFFFF_FFFC;
            end
        end
    endtask

    task automatic drive(input logic rst, input logic [4:0] s, input logic w,
                         input logic [31:0] d, input logic [31:0] p, input logic b,
                         input logic ev, input logic [4:0] ec, input logic er,
                         input logic [5:0] hw);
        reset = rst; bus.sel = s; bus.we = w; bus.din = d;
        pc = p; bd = b; exc_valid = ev; exc_code_in = ec; eret = er; hw_int = hw;
        model_and_push();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] s, input logic [5:0] hw);
        drive(1'b0, s, 1'b0, 32'd0, 32'h0000_1000, 1'b0, 1'b0, 5'd0, 1'b0, hw);
    endtask

    task automatic wr(input logic [4:0] s, input logic [31:0] d, input logic [5:0] hw);
        drive(1'b0, s, 1'b1, d, 32'h0000_1000, 1'b0, 1'b0, 5'd0, 1'b0, hw);
    endtask

    task automatic do_eret(input logic [5:0] hw);
        drive(1'b0, 5'd0, 1'b0, 32'd0, 32'h0000_1000, 1'b0, 1'b0, 5'd0, 1'b1, hw);
    endtask

    // Monitor: compare every predicted cycle in the middle of that cycle.
    exp_t mon_e;
    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            mon_e = sbq.pop_front();
            checks = checks + 3;
            if (req !== mon_e.req) begin
                failures = failures + 1;
                $display("FAIL req sel=%0d got=%b exp=%b at %0t", mon_e.sel, req, mon_e.req, $time);
            end
            if (bus.dout !== mon_e.dout) begin
                failures = failures + 1;
                $display("FAIL dout sel=%0d got=%h exp=%h at %0t", mon_e.sel, bus.dout, mon_e.dout, $time);
            end
            if (epc_out !== mon_e.epc) begin
                failures = failures + 1;
                $display("FAIL epc_out got=%h exp=%h at %0t", epc_out, mon_e.epc, $time);
            end
        end
    end

    initial begin
        int unsigned wait_cnt;
        logic [4:0]  rs;
        logic [31:0] rp;
        logic        rb;

        m_sr = 32'd0; m_cause = 32'd0; m_epc = 32'd0;
        reset = 1'b1; bus.sel = 5'd0; bus.we = 1'b0; bus.din = 32'd0;
        pc = 32'd0; bd = 1'b0; exc_valid = 1'b0; exc_code_in = 5'd0;
        eret = 1'b0; hw_int = 6'd0;
        repeat (3) @(posedge clk);
        #1;

        // Reset values
        rd(5'd12, 6'd0); rd(5'd13, 6'd0); rd(5'd14, 6'd0); rd(5'd15, 6'd0);
        rd(5'd7, 6'd0);
        checks = checks + 1;
        if (handler_pc !== HPC) begin
            failures = failures + 1;
            $display("FAIL handler_pc got=%h exp=%h", handler_pc, HPC);
        end

        // Timer interrupt
        wr(5'd12, 32'h0000_0401, 6'd0);
        drive(1'b0, 5'd0, 1'b0, 32'd0, 32'h0000_3010, 1'b0, 1'b0, 5'd0, 1'b0, 6'd1);
        rd(5'd12, 6'd1); rd(5'd14, 6'd1); rd(5'd13, 6'd1);
        do_eret(6'd0);

        // Masked interrupt
        wr(5'd12, 32'h0000_0801, 6'd1);
        rd(5'd13, 6'd1); rd(5'd13, 6'd0);

        // Delay-slot exception, then a second exception while EXL=1
        drive(1'b0, 5'd0, 1'b0, 32'd0, 32'h0000_3020, 1'b1, 1'b1, 5'd10, 1'b0, 6'd0);
        rd(5'd14, 6'd0); rd(5'd13, 6'd0); rd(5'd12, 6'd0);
        drive(1'b0, 5'd13, 1'b0, 32'd0, 32'h0000_3030, 1'b0, 1'b1, 5'd4, 1'b0, 6'd0);
        rd(5'd13, 6'd0);
        do_eret(6'd0);

        // Interrupt and exception together, with a dropped EPC write
        wr(5'd12, 32'h0000_0401, 6'd0);
        drive(1'b0, 5'd14, 1'b1, 32'hDEAD_0000, 32'h0000_3040, 1'b0, 1'b1, 5'd12, 1'b0, 6'd1);
        rd(5'd14, 6'd1); rd(5'd13, 6'd1);

        // eret with the interrupt still pending: req returns one cycle later
        do_eret(6'd1);
        rd(5'd12, 6'd1);
        do_eret(6'd0);
        rd(5'd12, 6'd0);

        // pc=0 in a delay slot wraps EPC
        wr(5'd12, 32'h0000_0000, 6'd0);
        drive(1'b0, 5'd0, 1'b0, 32'd0, 32'h0000_0000, 1'b1, 1'b1, 5'd3, 1'b0, 6'd0);
        rd(5'd14, 6'd0); rd(5'd13, 6'd0);

        // mtc0 SR with eret: written EXL wins
        drive(1'b0, 5'd12, 1'b1, 32'hFFFF_FFFF, 32'h0000_1000, 1'b0, 1'b0, 5'd0, 1'b1, 6'd0);
        rd(5'd12, 6'd0);
        wr(5'd12, 32'h0000_0000, 6'd0);

        // Write masking and read-only registers; same-cycle read returns old value
        wr(5'd14, 32'h1234_5677, 6'd0);
        wr(5'd14, 32'hABCD_EF03, 6'd0);
        rd(5'd14, 6'd0);
        wr(5'd13, 32'hFFFF_FFFF, 6'd0);
        wr(5'd15, 32'h0000_0000, 6'd0);
        rd(5'd13, 6'd0); rd(5'd15, 6'd0);

        // Reset in the middle of a handler
        drive(1'b0, 5'd0, 1'b0, 32'd0, 32'h0000_5000, 1'b0, 1'b1, 5'd8, 1'b0, 6'd2);
        drive(1'b1, 5'd12, 1'b0, 32'd0, 32'h0000_5004, 1'b0, 1'b0, 5'd0, 1'b0, 6'd2);
        rd(5'd12, 6'd0); rd(5'd13, 6'd0); rd(5'd14, 6'd0);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            case ($urandom_range(0, 5))
                0: rs = 5'd12;
                1: rs = 5'd13;
                2: rs = 5'd14;
                3: rs = 5'd15;
                default: rs = 5'($urandom);
            endcase
            rp = $urandom & 32'hFFFF_FFFC;
            rb = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 40) == 0) begin
                rp = 32'd0;
                rb = 1'b1;
            end
            drive(($urandom_range(0, 60) == 0), rs, ($urandom_range(0, 3) == 0),
                  $urandom, rp, rb, ($urandom_range(0, 6) == 0), 5'($urandom),
                  ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0);
        end

        rd(5'd0, 6'd0);
        wait_cnt = 0;
        while (sbq.size() > 0 && wait_cnt < 10) begin
            @(posedge clk);
            wait_cnt++;
        end
        checks = checks + 1;
        if (sbq.size() != 0) begin
            failures = failures + 1;
            $display("FAIL drain pending=%0d exp=0", sbq.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
